// File: rtl/receipt_emitter_if.sv
// receipt_emitter_if
//   Groups the two streaming channels of the receipt emitter:
//     instruction channel : instr_valid / instr_ready / instr_opcode / instr_operand
//     receipt channel     : rcpt_valid / rcpt_ready / rcpt_pre_mu / rcpt_post_mu /
//                           rcpt_opcode / rcpt_operand (+ rcpt_seq with RECEIPT_SEQ_EN)
//   master : the emitter side (accepts instructions, produces receipts)
//   slave  : the environment side (retire stage and receipt consumer)
//   Optional build macro: RECEIPT_SEQ_EN adds rcpt_seq [SEQ_W-1:0].
interface receipt_emitter_if
`ifdef RECEIPT_SEQ_EN
  #(parameter int SEQ_W = 16)
`endif
  ;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [31:0] instr_operand;
  logic        rcpt_valid;
  logic        rcpt_ready;
  logic [31:0] rcpt_pre_mu;
  logic [31:0] rcpt_post_mu;
  logic [7:0]  rcpt_opcode;
  logic [31:0] rcpt_operand;
`ifdef RECEIPT_SEQ_EN
  logic [SEQ_W-1:0] rcpt_seq;
`endif

  modport master (
    input  instr_valid, instr_opcode, instr_operand, rcpt_ready,
`ifdef RECEIPT_SEQ_EN
    output rcpt_seq,
`endif
    output instr_ready, rcpt_valid, rcpt_pre_mu, rcpt_post_mu, rcpt_opcode, rcpt_operand
  );

  modport slave (
    output instr_valid, instr_opcode, instr_operand, rcpt_ready,
`ifdef RECEIPT_SEQ_EN
    input  rcpt_seq,
`endif
    input  instr_ready, rcpt_valid, rcpt_pre_mu, rcpt_post_mu, rcpt_opcode, rcpt_operand
  );
endinterface

// File: rtl/receipt_emitter.sv
// receipt_emitter
//   Transmit side of the receipt protocol. Accepts retired instructions, computes
//   their cost, advances the mu accumulator and queues chained receipts
//   {pre_mu, post_mu, opcode, operand} in a first-word-fall-through FIFO.
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   bus (master)    instruction and receipt handshake channels
//   mu_load         pulse: load accumulator with mu_load_value, clear error, go RUN
//   mu_load_value   value for mu_load
//   fault_clear     pulse: FAULT -> RUN, clear error, keep accumulator
//   mu_total        registered accumulator
//   state_o         RUN=0, HALTED=1, FAULT=2
//   error_code      0 none, 3 unknown opcode, 4 overflow (sticky until cleared)
// Optional build macro: RECEIPT_SEQ_EN adds a per-receipt sequence index (rcpt_seq).
module receipt_emitter #(
  parameter int FIFO_DEPTH = 4
`ifdef RECEIPT_SEQ_EN
  , parameter int SEQ_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  receipt_emitter_if.master    bus,
  input  logic                 mu_load,
  input  logic [31:0]          mu_load_value,
  input  logic                 fault_clear,
  output logic [31:0]          mu_total,
  output logic [1:0]           state_o,
  output logic [31:0]          error_code
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_HALTED = 2'd1, S_FAULT = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] pre;
    logic [31:0] post;
    logic [7:0]  op;
    logic [31:0] operand;
`ifdef RECEIPT_SEQ_EN
    logic [SEQ_W-1:0] seq;
`endif
  } entry_t;

  function automatic logic is_known(input logic [7:0] op);
    return (op <= 8'h10) || (op == 8'hFF);
  endfunction

  // REVEAL packs two cost bytes; HALT is free; everything else costs the low byte.
  function automatic logic [31:0] instr_cost(input logic [7:0] op, input logic [31:0] operand);
    case (op)
      8'h0F:   return {16'h0, operand[23:16], operand[7:0]};
      8'hFF:   return 32'h0;
      default: return {24'h0, operand[7:0]};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] err_q, err_d;
  entry_t      mem_q [FIFO_DEPTH];
  entry_t      mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
`ifdef RECEIPT_SEQ_EN
  logic [SEQ_W-1:0] seq_q, seq_d;
`endif

  logic        full, xfer, known, do_push, do_pop;
  logic [31:0] cost;
  logic [32:0] sum;
  entry_t      new_entry;
  entry_t      head;

  always_comb begin
    full  = (count_q == CNT_FULL);
    // No pass-through when full: a same-cycle pop does not raise ready.
    bus.instr_ready = !rst && (state_q == S_RUN) && !full && !mu_load;
    bus.rcpt_valid  = (count_q != '0);
    xfer    = bus.instr_valid && bus.instr_ready;
    known   = is_known(bus.instr_opcode);
    cost    = instr_cost(bus.instr_opcode, bus.instr_operand);
    sum     = {1'b0, acc_q} + {1'b0, cost};
    do_push = xfer && known && !sum[32];
    do_pop  = bus.rcpt_valid && bus.rcpt_ready;

    new_entry.pre     = acc_q;
    new_entry.post    = sum[31:0];
    new_entry.op      = bus.instr_opcode;
    new_entry.operand = bus.instr_operand;
`ifdef RECEIPT_SEQ_EN
    new_entry.seq     = seq_q;
`endif
  end

  // Control: accumulator, error code and FSM; mu_load overrides everything.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
`ifdef RECEIPT_SEQ_EN
    seq_d   = seq_q;
`endif
    if (mu_load) begin
      acc_d   = mu_load_value;
      err_d   = 32'd0;
      state_d = S_RUN;
`ifdef RECEIPT_SEQ_EN
      seq_d   = '0;
`endif
    end else if (xfer) begin
      if (!known) begin
        err_d   = 32'd3;
        state_d = S_FAULT;
      end else if (sum[32]) begin
        err_d   = 32'd4;
        state_d = S_FAULT;
      end else begin
        acc_d = sum[31:0];
`ifdef RECEIPT_SEQ_EN
        seq_d = seq_q + SEQ_W'(1);
`endif
        if (bus.instr_opcode == 8'hFF) state_d = S_HALTED;
      end
    end else if (fault_clear && state_q == S_FAULT) begin
      err_d   = 32'd0;
      state_d = S_RUN;
    end
  end

  // Receipt queue: push and pop may both happen in one cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      acc_q    <= 32'd0;
      err_q    <= 32'd0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef RECEIPT_SEQ_EN
      seq_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      err_q    <= err_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef RECEIPT_SEQ_EN
      seq_q    <= seq_d;
`endif
    end
  end

  always_comb begin
    head             = mem_q[rd_ptr_q];
    bus.rcpt_pre_mu  = head.pre;
    bus.rcpt_post_mu = head.post;
    bus.rcpt_opcode  = head.op;
    bus.rcpt_operand = head.operand;
`ifdef RECEIPT_SEQ_EN
    bus.rcpt_seq     = head.seq;
`endif
    mu_total   = acc_q;
    state_o    = state_q;
    error_code = err_q;
  end
endmodule

// File: tb/tb_receipt_emitter.sv
// tb_receipt_emitter
//   Directed scenarios followed by a randomized phase, all checked against a
//   queue-based reference model of the receipt emitter.
module tb_receipt_emitter;
  logic        clk = 1'b0;
  logic        rst;
  logic        mu_load, fault_clear;
  logic [31:0] mu_load_value;
  logic [31:0] mu_total, error_code;
  logic [1:0]  state_o;

  always #5 clk = ~clk;

  receipt_emitter_if bus ();

  receipt_emitter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mu_load(mu_load), .mu_load_value(mu_load_value), .fault_clear(fault_clear),
    .mu_total(mu_total), .state_o(state_o), .error_code(error_code)
  );

  typedef struct {
    logic [31:0] pre;
    logic [31:0] post;
    logic [7:0]  op;
    logic [31:0] operand;
    int unsigned seq;
  } rcpt_t;

  rcpt_t       q[$];
  logic [31:0] m_acc, m_err;
  int          m_st;
  int unsigned m_seq;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_known(input logic [7:0] op);
    return (op <= 8'h10) || (op == 8'hFF);
  endfunction

  function automatic longint m_cost(input logic [7:0] op, input logic [31:0] operand);
    if (op == 8'h0F) return longint'(operand[23:16]) * 256 + longint'(operand[7:0]);
    if (op == 8'hFF) return 0;
    return longint'(operand[7:0]);
  endfunction

  task automatic model_reset();
    q.delete();
    m_acc = 32'd0;
    m_err = 32'd0;
    m_st  = 0;
    m_seq = 0;
  endtask

  // Called just after an active edge with inputs already driven; checks the
  // DUT against the model, advances one clock, and updates the model.
  task automatic cycle();
    bit     rdy, xfer, pop;
    longint s;
    rcpt_t  r;
    #1;
    rdy = (m_st == 0) && (q.size() < 4) && !mu_load;
    chk("instr_ready", 32'(bus.instr_ready), 32'(rdy));
    chk("rcpt_valid", 32'(bus.rcpt_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("rcpt_pre_mu", bus.rcpt_pre_mu, q[0].pre);
      chk("rcpt_post_mu", bus.rcpt_post_mu, q[0].post);
      chk("rcpt_opcode", 32'(bus.rcpt_opcode), 32'(q[0].op));
      chk("rcpt_operand", bus.rcpt_operand, q[0].operand);
`ifdef RECEIPT_SEQ_EN
      chk("rcpt_seq", 32'(bus.rcpt_seq), 32'(q[0].seq));
`endif
    end
    chk("mu_total", mu_total, m_acc);
    chk("state_o", 32'(state_o), 32'(m_st));
    chk("error_code", error_code, m_err);
    xfer = bus.instr_valid && rdy;
    pop  = (q.size() != 0) && bus.rcpt_ready;
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (mu_load) begin
      m_acc = mu_load_value; m_err = 32'd0; m_st = 0; m_seq = 0;
    end else if (xfer) begin
      if (!m_known(bus.instr_opcode)) begin
        m_err = 32'd3; m_st = 2;
      end else begin
        s = longint'(m_acc) + m_cost(bus.instr_opcode, bus.instr_operand);
        if (s > 64'hFFFF_FFFF) begin
          m_err = 32'd4; m_st = 2;
        end else begin
          r.pre = m_acc; r.post = s[31:0]; r.op = bus.instr_opcode;
          r.operand = bus.instr_operand; r.seq = m_seq;
          q.push_back(r);
          m_seq = (m_seq + 1) % 65536;
          m_acc = s[31:0];
          if (bus.instr_opcode == 8'hFF) m_st = 1;
        end
      end
    end else if (fault_clear && m_st == 2) begin
      m_err = 32'd0; m_st = 0;
    end
    #1;
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] operand);
    bus.instr_valid = 1'b1; bus.instr_opcode = op; bus.instr_operand = operand;
    cycle();
    bus.instr_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] v);
    mu_load = 1'b1; mu_load_value = v;
    cycle();
    mu_load = 1'b0;
  endtask

  function automatic logic [7:0] pick_op();
    int r;
    r = $urandom_range(0, 19);
    if (r <= 11) return 8'($urandom_range(0, 16));
    if (r == 12) return 8'h0F;
    if (r == 13) return 8'hFF;
    if (r == 14) return 8'($urandom_range(17, 254));
    return 8'h05;
  endfunction

  initial begin
    rst = 1'b1; mu_load = 1'b0; fault_clear = 1'b0; mu_load_value = 32'd0;
    bus.instr_valid = 1'b0; bus.instr_opcode = 8'h00; bus.instr_operand = 32'd0;
    bus.rcpt_ready = 1'b0;
    model_reset();

    // Reset state
    #2;
    chk("rst_instr_ready", 32'(bus.instr_ready), 32'd0);
    chk("rst_rcpt_valid", 32'(bus.rcpt_valid), 32'd0);
    chk("rst_rcpt_pre", bus.rcpt_pre_mu, 32'd0);
    chk("rst_rcpt_post", bus.rcpt_post_mu, 32'd0);
    chk("rst_mu_total", mu_total, 32'd0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_error", error_code, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: load 100, op 0x05 cost 5
    load(32'd100);
    send(8'h05, 32'h0000_0005);
    chk("t1_pre", bus.rcpt_pre_mu, 32'd100);
    chk("t1_post", bus.rcpt_post_mu, 32'd105);
    chk("t1_mu_total", mu_total, 32'd105);

    // 2: REVEAL 0x00020003 -> 105 + 512 + 3
    send(8'h0F, 32'h0002_0003);
    bus.rcpt_ready = 1'b1;
    cycle();
    chk("t2_pre", bus.rcpt_pre_mu, 32'd105);
    chk("t2_post", bus.rcpt_post_mu, 32'd620);
    cycle();
    bus.rcpt_ready = 1'b0;

    // 3: backpressure, 5 offers into a 4-deep queue
    for (int i = 0; i < 5; i++) begin
      bus.instr_valid = 1'b1;
      bus.instr_opcode = 8'($urandom_range(0, 14));
      bus.instr_operand = $urandom;
      if (i == 4) begin
        #1;
        chk("t3_ready_when_full", 32'(bus.instr_ready), 32'd0);
      end
      cycle();
    end
    bus.instr_valid = 1'b0;
    bus.rcpt_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    bus.rcpt_ready = 1'b0;

    // 4: overflow
    load(32'hFFFF_FFF0);
    send(8'h00, 32'h0000_0020);
    chk("t4_rcpt_valid", 32'(bus.rcpt_valid), 32'd0);
    chk("t4_error", error_code, 32'd4);
    chk("t4_state", 32'(state_o), 32'd2);
    chk("t4_mu_total", mu_total, 32'hFFFF_FFF0);
    fault_clear = 1'b1; cycle(); fault_clear = 1'b0;
    chk("t4_clear_state", 32'(state_o), 32'd0);
    chk("t4_clear_error", error_code, 32'd0);

    // 5: unknown opcode, then HALT
    send(8'h42, 32'h0000_0011);
    chk("t5_error", error_code, 32'd3);
    chk("t5_state", 32'(state_o), 32'd2);
    chk("t5_rcpt_valid", 32'(bus.rcpt_valid), 32'd0);
    fault_clear = 1'b1; cycle(); fault_clear = 1'b0;
    send(8'hFF, 32'h0000_00AB);
    chk("t5_halt_pre", bus.rcpt_pre_mu, 32'hFFFF_FFF0);
    chk("t5_halt_post", bus.rcpt_post_mu, 32'hFFFF_FFF0);
    chk("t5_halt_state", 32'(state_o), 32'd1);
    chk("t5_halt_ready", 32'(bus.instr_ready), 32'd0);
    bus.rcpt_ready = 1'b1; cycle(); bus.rcpt_ready = 1'b0;

    // 6: asynchronous reset with two receipts queued
    load(32'd7);
    send(8'h01, 32'h0000_0003);
    send(8'h02, 32'h0000_0004);
    chk("t6_queued", 32'(bus.rcpt_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_rcpt_valid", 32'(bus.rcpt_valid), 32'd0);
    chk("t6_rst_mu_total", mu_total, 32'd0);
    chk("t6_rst_state", 32'(state_o), 32'd0);
    chk("t6_rst_ready", 32'(bus.instr_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    send(8'h03, 32'h0000_0009);
`ifdef RECEIPT_SEQ_EN
    chk("t6_seq_restart", 32'(bus.rcpt_seq), 32'd0);
`endif
    chk("t6_pre_after_rst", bus.rcpt_pre_mu, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.instr_valid   = ($urandom_range(0, 3) != 0);
      bus.instr_opcode  = pick_op();
      bus.instr_operand = $urandom;
      mu_load           = ($urandom_range(0, 19) == 0);
      mu_load_value     = ($urandom_range(0, 1) == 1) ? $urandom
                                                      : (32'hFFFF_FE00 + 32'($urandom_range(0, 511)));
      fault_clear       = ($urandom_range(0, 9) == 0);
      bus.rcpt_ready    = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
